// File: rtl/mc_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctl_pkg
//  Description : Shared definitions for the multi-cycle MIPS main control FSM.
//                Holds the opcode and ALUOp constants shared with alu_ctl, the
//                state encoding, and the bundled control-word type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctl_pkg;

  // Opcode field IR[31:26] of the supported instructions
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;

  // ALUOp encoding understood by alu_ctl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // Operand B select
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; 13..15 are unused encodings
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_e;

  // Datapath control word produced by the decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_source;
  } ctl_t;

endpackage : mc_ctl_pkg
`default_nettype wire

// File: rtl/mc_ctl_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctl_dec
//  Description : Purely combinational control decoder. Maps the current
//                controller state (plus op for IEXEC and mem_ready for the
//                Mealy fetch strobes) onto the datapath control word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctl_dec
  import mc_ctl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctl_t       ctl_o
);

  // Control word per state; everything idle by default, sign-extend by default
  always_comb begin
    ctl_o        = '0;
    ctl_o.ext_op = 1'b1;
    case (state_i)
      S_RESET: begin
        ctl_o = '0;
      end
      S_FETCH: begin
        // PC <= PC+4 and IR load happen only on the completing cycle
        ctl_o.mem_read  = 1'b1;
        ctl_o.iord      = 1'b0;
        ctl_o.alu_src_a = 1'b0;
        ctl_o.alu_src_b = SRCB_FOUR;
        ctl_o.alu_op    = ALUOP_ADD;
        ctl_o.pc_source = PCSRC_ALU;
        ctl_o.ir_write  = mem_ready_i;
        ctl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target speculatively computed into ALUOut
        ctl_o.alu_src_a = 1'b0;
        ctl_o.alu_src_b = SRCB_BOFF;
        ctl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = SRCB_IMM;
        ctl_o.alu_op    = ALUOP_ADD;
        ctl_o.ext_op    = 1'b1;
      end
      S_MEMRD: begin
        ctl_o.mem_read = 1'b1;
        ctl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl_o.reg_dst    = 1'b0;
        ctl_o.mem_to_reg = 1'b1;
        ctl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctl_o.mem_write = 1'b1;
        ctl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = SRCB_B;
        ctl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctl_o.reg_dst    = 1'b1;
        ctl_o.mem_to_reg = 1'b0;
        ctl_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctl_o.alu_src_a     = 1'b1;
        ctl_o.alu_src_b     = SRCB_B;
        ctl_o.alu_op        = ALUOP_SUB;
        ctl_o.pc_write_cond = 1'b1;
        ctl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl_o.pc_write  = 1'b1;
        ctl_o.pc_source = PCSRC_JUMP;
      end
      S_IEXEC: begin
        // ori is a logical op and takes a zero-extended immediate
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = SRCB_IMM;
        if (op_i == OP_ORI) begin
          ctl_o.alu_op = ALUOP_OR;
          ctl_o.ext_op = 1'b0;
        end else begin
          ctl_o.alu_op = ALUOP_ADD;
          ctl_o.ext_op = 1'b1;
        end
      end
      S_IWB: begin
        ctl_o.reg_dst    = 1'b0;
        ctl_o.mem_to_reg = 1'b0;
        ctl_o.reg_write  = 1'b1;
      end
      default: begin
        ctl_o = '0;
      end
    endcase
  end

endmodule : mc_ctl_dec
`default_nettype wire

// File: rtl/mc_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctl
//  Description : Multi-cycle main control FSM for the MIPS datapath. Owns the
//                state register, next-state logic, retired-instruction counter
//                and illegal-opcode pulse; output decoding is in mc_ctl_dec.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctl
  import mc_ctl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               ExtOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  state_e             state_q;
  state_e             state_d;
  logic               retire;
  logic               illegal_d;
  logic               illegal_q;
  logic [COUNT_W-1:0] count_q;
  ctl_t               ctl;

  // Next state, plus which transitions retire an instruction or flag a bad op
  always_comb begin
    state_d   = S_FETCH;
    retire    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:            state_d = S_EXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          default: begin
            // Unsupported opcode: abandon the instruction without retiring it
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        // A store retires on the cycle its write is accepted
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_IEXEC:  state_d = S_IWB;
      S_IWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // State, illegal pulse and retire counter; async reset forces RESET so all
  // decoded strobes drop immediately, even in the middle of a memory access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  mc_ctl_dec u_dec (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .ctl_o       (ctl)
  );

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign ExtOp       = ctl.ext_op;
  assign PCSource    = ctl.pc_source;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule : mc_ctl
`default_nettype wire

// File: tb/tb_mc_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctl
//  Description : Self-checking bench for mc_ctl. A phase-list model (each
//                opcode expands to its list of post-decode phases) predicts
//                the control word, illegal pulse and retire count; a 4-bit
//                counter instance shares the stimulus to exercise wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] op = 6'd0;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [31:0] instr_count;

  logic b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite;
  logic b_MemtoReg, b_RegDst, b_RegWrite, b_ALUSrcA, b_ExtOp, b_illegal_op;
  logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSource;
  logic [3:0] b_instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_ctl #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  mc_ctl #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD),
    .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
    .MemtoReg(b_MemtoReg), .RegDst(b_RegDst), .RegWrite(b_RegWrite),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .ExtOp(b_ExtOp),
    .PCSource(b_PCSource), .illegal_op(b_illegal_op), .instr_count(b_instr_count)
  );

  wire [16:0] dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                         ExtOp, PCSource};
  wire [16:0] b_ctl   = {b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite,
                         b_IRWrite, b_MemtoReg, b_RegDst, b_RegWrite, b_ALUSrcA,
                         b_ALUSrcB, b_ALUOp, b_ExtOp, b_PCSource};

  // ---------------- reference model ----------------
  typedef enum int {P_RST, P_IF, P_ID, P_MA, P_MR, P_MW, P_MS, P_EX,
                    P_RW, P_BR, P_JP, P_IE, P_IW} ph_e;

  ph_e         m_ph = P_RST;
  ph_e         m_q[$];
  int unsigned m_cnt = 0;
  logic        m_ill = 1'b0;
  logic        m_ill_n;

  // Phases an instruction goes through after DECODE; empty = unsupported
  function automatic void plan(input logic [5:0] o);
    m_q.delete();
    case (o)
      6'd0:  begin m_q.push_back(P_EX); m_q.push_back(P_RW); end
      6'd35: begin m_q.push_back(P_MA); m_q.push_back(P_MR); m_q.push_back(P_MW); end
      6'd43: begin m_q.push_back(P_MA); m_q.push_back(P_MS); end
      6'd4:  m_q.push_back(P_BR);
      6'd2:  m_q.push_back(P_JP);
      6'd8, 6'd13: begin m_q.push_back(P_IE); m_q.push_back(P_IW); end
      default: ;
    endcase
  endfunction

  // Leaving the last phase of an instruction retires it
  function automatic void advance();
    if (m_q.size() == 0) begin
      m_cnt = m_cnt + 1;
      m_ph  = P_IF;
    end else begin
      m_ph = m_q.pop_front();
    end
  endfunction

  function automatic logic [16:0] exp_ctl(input ph_e p, input logic [5:0] o,
                                          input logic mr);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ext;
    logic [1:0] sb, aop, psrc;
    pw = 0; pwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rdst = 0; rw = 0; sa = 0; sb = 2'd0; aop = 2'd0; psrc = 2'd0;
    ext = (p != P_RST);
    case (p)
      P_IF: begin mrd = 1; sb = 2'd1; irw = mr; pw = mr; end
      P_ID: sb = 2'd3;
      P_MA: begin sa = 1; sb = 2'd2; end
      P_MR: begin mrd = 1; iord = 1; end
      P_MW: begin m2r = 1; rw = 1; end
      P_MS: begin mwr = 1; iord = 1; end
      P_EX: begin sa = 1; aop = 2'd2; end
      P_RW: begin rdst = 1; rw = 1; end
      P_BR: begin sa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
      P_JP: begin pw = 1; psrc = 2'd2; end
      P_IE: begin
        sa = 1; sb = 2'd2;
        if (o == 6'd13) begin aop = 2'd3; ext = 0; end
      end
      P_IW: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, ext, psrc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model advances on each rising edge from the inputs held across it
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_ph = P_RST; m_cnt = 0; m_ill = 1'b0; m_q.delete();
      end else begin
        m_ill_n = 1'b0;
        case (m_ph)
          P_RST: m_ph = P_IF;
          P_IF:  if (mem_ready) m_ph = P_ID;
          P_ID: begin
            plan(op);
            if (m_q.size() == 0) begin
              m_ill_n = 1'b1;
              m_ph    = P_IF;
            end else begin
              m_ph = m_q.pop_front();
            end
          end
          P_MR, P_MS: if (mem_ready) advance();
          default: advance();
        endcase
        m_ill = m_ill_n;
      end
    end
  end

  // Compare every cycle, mid-low-phase; reset takes effect without a clock
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_ph = P_RST; m_cnt = 0; m_ill = 1'b0; m_q.delete();
      end
      chk("ctl",     {15'd0, dut_ctl}, {15'd0, exp_ctl(m_ph, op, mem_ready)});
      chk("ctl4",    {15'd0, b_ctl},   {15'd0, exp_ctl(m_ph, op, mem_ready)});
      chk("illegal", {31'd0, illegal_op}, {31'd0, m_ill});
      chk("count",   instr_count, m_cnt);
      chk("count4",  {28'd0, b_instr_count}, m_cnt % 16);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic mr, input logic [5:0] o);
    @(negedge clk);
    rst_n = r; mem_ready = mr; op = o;
    #1;
  endtask

  logic [5:0] ops [9] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13, 6'd63, 6'd17};

  initial begin
    // Held in reset
    step(0, 1, 0);
    step(0, 1, 0);
    chk("rst_ctl", {15'd0, dut_ctl}, 32'd0);
    chk("rst_cnt", instr_count, 32'd0);
    // R-type: RESET, FETCH, DECODE, EXEC, RWB, FETCH
    step(1, 1, 0);  chk("c0_reset_memread", {31'd0, MemRead}, 32'd0);
    step(1, 1, 0);  chk("c1_fetch_strobes", {29'd0, MemRead, IRWrite, PCWrite}, 32'd7);
    step(1, 1, 0);  chk("c2_decode_srcb", {30'd0, ALUSrcB}, 32'd3);
    step(1, 1, 0);  chk("c3_exec", {29'd0, ALUOp, RegWrite}, 32'd4);
    step(1, 1, 0);  chk("c4_rwb", {30'd0, RegWrite, RegDst}, 32'd3);
    // lw with two stall cycles in MEMRD
    step(1, 1, 35); chk("c5_cnt_r", instr_count, 32'd1);
    step(1, 1, 35);
    step(1, 1, 35); chk("c7_memadr", {29'd0, ALUSrcA, ALUSrcB}, 32'd6);
    step(1, 0, 35); chk("c8_memrd", {30'd0, MemRead, IorD}, 32'd3);
    step(1, 0, 35); chk("c9_memrd", {30'd0, MemRead, IorD}, 32'd3);
    step(1, 1, 35); chk("c10_memrd", {30'd0, MemRead, IorD}, 32'd3);
    step(1, 1, 35); chk("c11_memwb", {30'd0, MemtoReg, RegWrite}, 32'd3);
    // ori then addi
    step(1, 1, 13); chk("c12_cnt_lw", instr_count, 32'd2);
    step(1, 1, 13);
    step(1, 1, 13); chk("c14_ori", {27'd0, ALUOp, ExtOp, ALUSrcB}, 32'b11_0_10);
    step(1, 1, 13);
    step(1, 1, 8);  chk("c16_cnt", instr_count, 32'd3);
    step(1, 1, 8);
    step(1, 1, 8);  chk("c18_addi", {27'd0, ALUOp, ExtOp, ALUSrcB}, 32'b00_1_10);
    step(1, 1, 8);
    // illegal opcode
    step(1, 1, 63); chk("c20_cnt", instr_count, 32'd4);
    step(1, 1, 63);
    step(1, 1, 43); chk("c22_illegal", {31'd0, illegal_op}, 32'd1);
    chk("c22_cnt", instr_count, 32'd4);
    step(1, 1, 43); chk("c23_illegal_clr", {31'd0, illegal_op}, 32'd0);
    step(1, 1, 43);
    // async reset mid-store
    step(1, 0, 43); chk("c25_memwr", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("async_cnt", instr_count, 32'd0);
    chk("async_ctl", {15'd0, dut_ctl}, 32'd0);
    step(0, 1, 2);
    step(1, 1, 2);  chk("rel_reset", {31'd0, MemRead}, 32'd0);
    // 16 jumps: 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 2);
      chk("j_fetch", {31'd0, MemRead}, 32'd1);
      chk("j_cnt4", {28'd0, b_instr_count}, i % 16);
      step(1, 1, 2);
      step(1, 1, 2);
      chk("j_jump", {29'd0, PCWrite, PCSource}, 32'b1_10);
    end
    step(1, 1, 2);
    chk("j_wrap4", {28'd0, b_instr_count}, 32'd0);
    chk("j_cnt32", instr_count, 32'd16);
    // randomized traffic: op changes only between instructions
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      if (m_ph == P_IF || m_ph == P_RST) op = ops[$urandom_range(0, 8)];
      mem_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mc_ctl
`default_nettype wire

// File: doc/mc_ctl.md
Name: mc_ctl

Overview:
Multi-cycle main control FSM for the MIPS datapath. It sequences the shared ALU through fetch, decode, execute, memory and writeback phases. Each phase drives ALUOp[1:0] into alu_ctl, the ALU operand selects, and the register, memory and PC write enables. Memory phases use a ready handshake, so slow memory stalls the FSM. A retired-instruction counter and an illegal-opcode pulse are exported for debug.

Parameters:
COUNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
op  in  6  opcode field IR[31:26]; stable from DECODE until return to FETCH.
mem_ready  in  1  memory handshake; the access completes in a cycle where mem_ready=1.
PCWrite  out  1  unconditional PC write.
PCWriteCond  out  1  PC write when ALU Zero.
IorD  out  1  memory address select: 0=PC, 1=ALUOut.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  instruction register load.
MemtoReg  out  1  writeback select: 1=MDR.
RegDst  out  1  destination select: 1=rd, 0=rt.
RegWrite  out  1  register file write.
ALUSrcA  out  1  0=PC, 1=A.
ALUSrcB  out  2  00=B, 01=4, 10=signext/zeroext imm, 11=imm<<2.
ALUOp  out  2  to alu_ctl: 00 add, 01 sub, 10 funct, 11 or.
ExtOp  out  1  1=sign-extend imm, 0=zero-extend.
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target.
illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
instr_count  out  COUNT_W  number of retired instructions.

Behaviour:
- Supported opcodes: R-type 0, lw 35, sw 43, beq 4, j 2, addi 8, ori 13.
- States use a 4-bit encoding: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, IEXEC 11, IWB 12.
- Unlisted outputs are 0 in every state; ExtOp defaults to 1.
- Reset (rst_n=0, asynchronous):
  - state=RESET; instr_count=0; illegal_op=0.
  - All decoded outputs are 0, including MemWrite and RegWrite, immediately (no clock edge needed), even mid-access.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut). Next state by op:
  - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi/ori -> IEXEC.
  - Other opcodes -> FETCH; illegal_op is registered 1 on the next cycle only; the instruction is not retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH; retire.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1, then go to FETCH; retire on the completing cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH; retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH; retire.
- JUMP: PCWrite=1, PCSource=10. Next FETCH; retire.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - ori: ALUOp=11, ExtOp=0.
  - addi: ALUOp=00, ExtOp=1.
  - Next IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH; retire.
- Undefined state encodings (13-15): outputs 0, next state FETCH.
- instr_count: increments by 1 on the clock edge leaving a retiring state; wraps from 2^COUNT_W-1 to 0.
- Latency per instruction with mem_ready tied to 1: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3 cycles.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle; all outputs hold steady during the stall.

Decomposition:
- Shared include mips_defs.vh holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI);
  - ALUOp constants (00/01/10/11), shared with alu_ctl;
  - state encodings.
- One sub-module, mc_ctl_dec: combinational state+op+mem_ready -> control outputs.
- State register, next-state logic and the counter stay in mc_ctl.

Test Plan:
- Reset release with mem_ready=1, op=0 -> RESET, FETCH, DECODE, EXEC, RWB, FETCH; RegWrite=1 and RegDst=1 in RWB only; ALUOp=10 in EXEC; instr_count=1.
- lw (op=35) with mem_ready low 2 cycles in MEMRD -> MemRead=1, IorD=1 held 3 cycles; MEMWB asserts MemtoReg=1, RegWrite=1; total 7 cycles.
- ori (op=13) -> IEXEC shows ALUOp=11, ExtOp=0, ALUSrcB=10; addi (op=8) shows ALUOp=00, ExtOp=1.
- op=63 -> DECODE then FETCH; illegal_op=1 for exactly one cycle; instr_count unchanged.
- rst_n low during MEMWR with mem_ready=0 -> MemWrite drops to 0 before the next clock edge; instr_count=0; after release the FSM passes RESET then FETCH.
- COUNT_W=4, 16 j instructions (op=2) -> instr_count wraps 15 to 0; PCWrite=1 with PCSource=10 in each JUMP.
